// File: rtl/fact_accel_if.sv
// Data-memory side bus between the SoC decoder and fact_accel.
// master: SoC/core side, slave: accelerator side.
interface fact_accel_if;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    modport master (
        output we,
        output a,
        output wd,
        input  rd,
        input  irq
    );

    modport slave (
        input  we,
        input  a,
        input  wd,
        output rd,
        output irq
    );
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator, one multiply per cycle.
// Optional macro FACT_IRQ_EN adds a registered completion interrupt.
module fact_accel #(
    parameter int unsigned MAX_N = 12
) (
    input  logic        clk,
    input  logic        rst,
    fact_accel_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] MAX_N5 = 5'(MAX_N);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  n;
    logic [3:0]  cnt;
    logic [31:0] prod;
    logic [31:0] result;
    logic        done;
    logic        err;
    logic        busy;

    logic        wr_n;
    logic        wr_go;
    logic        wr_st;
    logic        go_ok;
    logic        go_err;
    logic        run_fin;
    logic        run_step;
    logic [35:0] mul;
    logic [31:0] rd_c;
    logic        unused_wd;

    assign unused_wd = ^bus.wd[31:4];

    // Register-select decode of the qualified write strobe.
    always_comb begin
        wr_n  = bus.we && (bus.a == 2'd0);
        wr_go = bus.we && (bus.a == 2'd1) && bus.wd[0];
        wr_st = bus.we && (bus.a == 2'd2);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic: only an in-range GO leaves IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (go_ok) state_nxt = RUN;
            RUN:  if (run_fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the per-cycle datapath strobes.
    always_comb begin
        busy     = (state == RUN);
        go_ok    = 1'b0;
        go_err   = 1'b0;
        run_fin  = 1'b0;
        run_step = 1'b0;
        unique case (state)
            IDLE: begin
                go_ok  = wr_go && ({1'b0, n} <= MAX_N5);
                go_err = wr_go && ({1'b0, n} > MAX_N5);
            end
            RUN: begin
                run_fin  = (cnt <= 4'd1);
                run_step = (cnt > 4'd1);
            end
            default: ;
        endcase
    end

    assign mul = {4'b0, prod} * {32'b0, cnt};

    // Datapath registers; completion sets are ordered last so they
    // win over a same-cycle STATUS clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n      <= 4'd0;
            cnt    <= 4'd0;
            prod   <= 32'd1;
            result <= 32'd0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr_n) begin
                n <= bus.wd[3:0];
            end
            if (wr_st) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (go_ok) begin
                prod <= 32'd1;
                cnt  <= n;
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (go_err) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if (run_step) begin
                prod <= mul[31:0];
                cnt  <= cnt - 4'd1;
            end
            if (run_fin) begin
                result <= prod;
                done   <= 1'b1;
            end
        end
    end

    // Combinational read mux for single-cycle loads.
    always_comb begin
        rd_c = 32'd0;
        unique case (bus.a)
            2'd0: rd_c = {28'b0, n};
            2'd1: rd_c = {31'b0, busy};
            2'd2: rd_c = {30'b0, err, done};
            2'd3: rd_c = result;
            default: rd_c = 32'd0;
        endcase
    end

    assign bus.rd = rd_c;

`ifdef FACT_IRQ_EN
    logic irq_q;

    // Interrupt rises with done and is dropped by a STATUS write or new GO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else if (go_err || run_fin) begin
            irq_q <= 1'b1;
        end else if (wr_st || go_ok) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_fact_accel.sv
// Directed testbench for fact_accel.
// Vectors use hand-computed factorials.
module tb_fact_accel;

`ifdef FACT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errs;

    fact_accel_if bus ();

    fact_accel #(.MAX_N(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] d);
        bus.a = addr;
        #1;
        d = bus.rd;
    endtask

    // Wait for done, counting edges; lat starts at the given value.
    task automatic wait_done(inout int lat, output int bsy);
        logic [31:0] st;
        logic [31:0] b;
        bsy = 0;
        rd_reg(2'd2, st);
        while (st[0] == 1'b0 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            rd_reg(2'd2, st);
            rd_reg(2'd1, b);
            if (st[0] == 1'b0) bsy += int'(b[0]);
        end
    endtask

    task automatic run_fact(input logic [3:0] nv, input logic [31:0] exp_res);
        logic [31:0] d;
        int lat;
        int bsy;
        int exp_lat;
        exp_lat = (nv == 4'd0) ? 1 : int'(nv);
        wr(2'd0, {28'b0, nv});
        wr(2'd1, 32'd1);
        rd_reg(2'd1, d);
        check($sformatf("busy_go n=%0d", nv), d, 32'd1);
        lat = 0;
        wait_done(lat, bsy);
        check($sformatf("lat n=%0d", nv), lat, exp_lat);
        check($sformatf("busy_cyc n=%0d", nv), bsy, exp_lat - 1);
        rd_reg(2'd2, d);
        check($sformatf("status n=%0d", nv), d, 32'd1);
        rd_reg(2'd1, d);
        check($sformatf("busy_end n=%0d", nv), d, 32'd0);
        rd_reg(2'd3, d);
        check($sformatf("result n=%0d", nv), d, exp_res);
        check($sformatf("irq n=%0d", nv), {31'b0, bus.irq}, {31'b0, IRQ_ON});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int lat;
        int bsy;
        n_checks = 0;
        n_errs   = 0;
        rst    = 1'b0;
        bus.we = 1'b0;
        bus.a  = 2'd0;
        bus.wd = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;

        rd_reg(2'd0, d); check("rst_n", d, 32'd0);
        rd_reg(2'd1, d); check("rst_busy", d, 32'd0);
        rd_reg(2'd2, d); check("rst_status", d, 32'd0);
        rd_reg(2'd3, d); check("rst_result", d, 32'd0);
        check("rst_irq", {31'b0, bus.irq}, 32'd0);

        // Reset in the middle of an n=9 run.
        wr(2'd0, 32'd9);
        wr(2'd1, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        rd_reg(2'd1, d); check("mid_rst_busy", d, 32'd0);
        rd_reg(2'd2, d); check("mid_rst_status", d, 32'd0);
        rd_reg(2'd3, d); check("mid_rst_result", d, 32'd0);
        rd_reg(2'd0, d); check("mid_rst_n", d, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rd_reg(2'd1, d); check("post_rst_busy", d, 32'd0);

        run_fact(4'd3, 32'd6);
        run_fact(4'd5, 32'h78);
        run_fact(4'd0, 32'd1);
        run_fact(4'd1, 32'd1);
        run_fact(4'd12, 32'h1C8CFC00);

        // Out-of-range n: error flagged at the GO edge, RESULT kept.
        wr(2'd0, 32'd13);
        wr(2'd1, 32'd1);
        rd_reg(2'd2, d); check("err13_status", d, 32'd3);
        rd_reg(2'd1, d); check("err13_busy", d, 32'd0);
        rd_reg(2'd3, d); check("err13_result", d, 32'h1C8CFC00);
        check("err13_irq", {31'b0, bus.irq}, {31'b0, IRQ_ON});
        @(posedge clk);
        #1;
        rd_reg(2'd1, d); check("err13_busy2", d, 32'd0);
        wr(2'd2, 32'd0);
        rd_reg(2'd2, d); check("err13_clr", d, 32'd0);
        check("err13_irq_clr", {31'b0, bus.irq}, 32'd0);

        // Only wd[3:0] lands in N; 15 is out of range.
        wr(2'd0, 32'h1F);
        rd_reg(2'd0, d); check("n_trunc", d, 32'hF);
        wr(2'd1, 32'd1);
        rd_reg(2'd2, d); check("err15_status", d, 32'd3);
        wr(2'd2, 32'hFFFF_FFFF);
        rd_reg(2'd2, d); check("err15_clr", d, 32'd0);

        // STATUS write on the completing edge: the set wins.
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd1);
        @(posedge clk);
        wr(2'd2, 32'd0);
        rd_reg(2'd2, d); check("coll_status", d, 32'd1);
        rd_reg(2'd3, d); check("coll_result", d, 32'd2);
        rd_reg(2'd1, d); check("coll_busy", d, 32'd0);
        wr(2'd2, 32'd0);
        rd_reg(2'd2, d); check("idle_clr", d, 32'd0);

        // GO with wd[0]=0 and RESULT writes are ignored.
        wr(2'd1, 32'd2);
        rd_reg(2'd1, d); check("go0_busy", d, 32'd0);
        wr(2'd3, 32'hDEAD_BEEF);
        rd_reg(2'd3, d); check("res_ro", d, 32'd2);

        // GO rewrite and N rewrite during an n=6 run.
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        @(posedge clk);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd2);
        lat = 3;
        wait_done(lat, bsy);
        check("mid_lat", lat, 6);
        rd_reg(2'd3, d); check("mid_result", d, 32'h2D0);
        rd_reg(2'd0, d); check("mid_n", d, 32'd2);
        check("mid_irq", {31'b0, bus.irq}, {31'b0, IRQ_ON});
        wr(2'd2, 32'd0);
        check("mid_irq_clr", {31'b0, bus.irq}, 32'd0);
        rd_reg(2'd2, d); check("mid_status_clr", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped factorial accelerator on the data-memory side of the single-cycle MIPS core. It consumes the core's data-memory request after SoC address decoding: word address bits from `alu_out`, write data `wd_dm`, and a block-qualified write enable. It returns a combinational read word that the SoC read mux steers into `rd_dm`. Software writes n and a go bit, then polls status. An iterative FSM computes n! with one multiply per cycle.

## Interface
- `MAX_N`, default 12: largest n accepted. 13! overflows 32 bits.
- `clk`  in  1: rising-edge clock, shared with the core.
- `rst`  in  1: reset, asynchronous assert, active-low.
- `we`  in  1: write strobe, already qualified by the SoC address decoder.
- `a`  in  2: register select, driven from `alu_out[3:2]`.
- `wd`  in  32: write data, driven from `wd_dm`.
- `rd`  out  32: read data, combinational from `a`.
- `irq`  out  1: completion interrupt. Only active with `FACT_IRQ_EN`; see Configuration.

## Operation
Register map (`a`):

- 0 N
  - Write: `n <= wd[3:0]`. Allowed at any time; does not disturb a running computation.
  - Read: `{28'b0, n}`.
- 1 GO
  - Write with `wd[0]=1` starts a computation. Ignored while busy.
  - Read: `{31'b0, busy}`.
- 2 STATUS
  - Read: `{30'b0, err, done}`.
  - Any write clears `done` and `err`.
- 3 RESULT
  - Read-only; writes are ignored.

FSM has two states, IDLE and RUN. `busy` = (state == RUN).

- IDLE, GO accepted, `n <= MAX_N`:
  - `prod <= 1`, `cnt <= n`, `done <= 0`, `err <= 0`, state to RUN.
- IDLE, GO accepted, `n > MAX_N`:
  - `done <= 1`, `err <= 1`; `result` unchanged; stay in IDLE.
- RUN, `cnt <= 1`:
  - `result <= prod`, `done <= 1`, state to IDLE.
- RUN, `cnt > 1`:
  - `prod <= low32(prod * cnt)`, `cnt <= cnt - 1`.

Arithmetic:
- `cnt` is 4-bit unsigned.
- The product is 32×4 unsigned, truncated to 32 bits. No truncation occurs for n ≤ 12.

Boundaries:
- n = 0 and n = 1 both yield 1.
- GO with `wd[0]=0` has no effect.
- STATUS write in the same cycle as a completing RUN step: the set wins, so `done=1` after the edge.
- A STATUS write clears a prior `done` even while idle.
- Reset mid-RUN aborts the computation; all state returns to reset values.

Reset values:
- state = IDLE
- `n` = 0
- `prod` = 1
- `cnt` = 0
- `result` = 0
- `done` = 0
- `err` = 0
- `rd` reflects these values (e.g. `a=3` reads 0)
- `irq` = 0

## Timing
- Writes take effect on the rising edge where `we=1`, matching the core's single-cycle store.
- Reads are combinational in the same cycle, as required by single-cycle `lw`.
- Latency from the GO edge to `done=1` visible:
  - n edges for 1 ≤ n ≤ MAX_N.
  - 1 edge for n = 0.
  - 1 edge for the error case.
- `busy` is high from the edge after GO until the edge that sets `done`.
- RESULT holds its last value until the next successful completion.

## Configuration
- Macro `FACT_IRQ_EN`.
- Defined:
  - `irq = done | err`, registered and asserted the same edge as `done`.
  - `irq` stays high until a STATUS write or a new accepted GO.
- Undefined:
  - `irq` is tied to 0. No extra flops.
  - All register behaviour is otherwise identical.

## Test plan
- Reset with `rst=0` mid-RUN for n=9, then release:
  - `busy=0`, STATUS=0, RESULT=0.
  - A subsequent n=3 run returns 6.
- Write N=5, GO=1:
  - `busy=1` for 5 edges.
  - STATUS=0x1 on the 5th edge.
  - RESULT=0x78.
- n=12:
  - RESULT=0x1C8CFC00 after 12 edges.
- n=0 and n=1:
  - Each gives RESULT=1 after 1 edge, `err=0`.
- n=13:
  - After 1 edge STATUS=0x3, `busy` never set, previous RESULT retained.
  - A STATUS write returns STATUS to 0.
- GO rewritten while busy (n=6), plus a write of N=2 mid-run:
  - Run unaffected; RESULT=720 (0x2D0).
  - N reads 2.
  - With `FACT_IRQ_EN`, `irq` rises with `done` and falls after a STATUS write.
